seq_divider_param: RTL and testbench

//  Multi-cycle restoring integer divider, one quotient bit per cycle, with per-operation signed/unsigned mode.

---
 rtl/seq_divider_param_if.sv | 27 ++
 rtl/seq_divider_param.sv | 158 +++++++++++++++
 tb/tb_seq_divider_param.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_param_if.sv
// Handshake bundle for seq_divider_param: an operand channel in and a result channel out.
// The master is the producer/consumer side; the slave is the divider.
interface seq_divider_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, sign, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, sign, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider producing one quotient bit per clock, with per-operation
// signed/unsigned mode, valid/ready on both sides and defined divide-by-zero/overflow results.
module seq_divider_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_divider_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] mag_dividend;
  logic [WIDTH-1:0] mag_divisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             is_overflow;

  // Magnitudes of the incoming operands; MIN maps to 2^(WIDTH-1) read as unsigned.
  assign mag_dividend = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign mag_divisor  = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  assign is_overflow  = bus.sign && (bus.dividend == MIN_VAL) && (bus.divisor == '1);

  assign shifted = {acc_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  // dvd_q doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (is_overflow) begin
            quot_d  = MIN_VAL;
            rem_d   = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            acc_d      = '0;
            dvd_d      = mag_dividend;
            dvs_d      = mag_divisor;
            neg_quot_d = bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_rem_d  = bus.sign && bus.dividend[WIDTH-1];
            cnt_d      = CNT_W'(WIDTH);
            state_d    = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          acc_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quot_d  = neg_quot_q ? -dvd_q : dvd_q;
        rem_d   = neg_rem_q ? -acc_q : acc_q;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Directed bench for seq_divider_param (WIDTH=32): literal expectations per vector plus an
// arithmetic reference model that a per-cycle monitor compares against the result channel.
module tb_seq_divider_param;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam int NORMAL_LAT = W + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } result_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  result_t exp_q[$];

  seq_divider_param_if #(.WIDTH(W)) bus ();

  seq_divider_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour from plain integer arithmetic (SV / and % truncate toward zero).
  function automatic result_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    result_t res;
    res = '0;
    if (b == '0) begin
      res.q   = '1;
      res.r   = a;
      res.dbz = 1'b1;
    end else if (s && a == MIN_VAL && b == '1) begin
      res.q   = MIN_VAL;
      res.r   = '0;
      res.ovf = 1'b1;
    end else if (s) begin
      res.q = $signed(a) / $signed(b);
      res.r = $signed(a) % $signed(b);
    end else begin
      res.q = a / b;
      res.r = a % b;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: in_ready tracks whether an operation is outstanding, and every valid
  // result must match the model for the oldest accepted operation.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("mon_in_ready", 64'(bus.in_ready), 64'(exp_q.size() == 0));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("mon_spurious_valid", 64'(bus.out_valid), 64'(0));
        end else begin
          check("mon_quotient", 64'(bus.quotient), 64'(exp_q[0].q));
          check("mon_remainder", 64'(bus.remainder), 64'(exp_q[0].r));
          check("mon_div_by_zero", 64'(bus.div_by_zero), 64'(exp_q[0].dbz));
          check("mon_overflow", 64'(bus.overflow), 64'(exp_q[0].ovf));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.sign, bus.dividend, bus.divisor));
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.in_ready !== 1'b1) check("stim_in_ready_timeout", 64'(bus.in_ready), 64'(1));
    bus.sign     = s;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands after the accept edge; the running operation must ignore them.
    bus.in_valid = 1'b0;
    bus.sign     = ~s;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0000_0000;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edbz, input logic eovf, input int elat, input int hold);
    int lat;
    logic [W-1:0] q0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < W + 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_quotient"}, 64'(bus.quotient), 64'(eq));
    check({name, "_remainder"}, 64'(bus.remainder), 64'(er));
    check({name, "_div_by_zero"}, 64'(bus.div_by_zero), 64'(edbz));
    check({name, "_overflow"}, 64'(bus.overflow), 64'(eovf));
    q0 = bus.quotient;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.sign     = 1'b0;
      bus.dividend = 32'h0000_0064;
      bus.divisor  = 32'h0000_0005;
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
      check({name, "_hold_quotient"}, 64'(bus.quotient), 64'(q0));
      check({name, "_hold_in_ready"}, 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_valid_drop"}, 64'(bus.out_valid), 64'(0));
    check({name, "_ready_back"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    result_t      m;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sign      = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_quotient", 64'(bus.quotient), 64'(0));
    check("reset_remainder", 64'(bus.remainder), 64'(0));
    check("reset_flags", 64'({bus.div_by_zero, bus.overflow}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));

    // Literal vectors pin the model as well as the DUT.
    m = model(1'b1, 32'hFFFF_FF9C, 32'd7);
    check("model_neg_q", 64'(m.q), 64'(32'hFFFF_FFF2));
    check("model_neg_r", 64'(m.r), 64'(32'hFFFF_FFFE));

    applyStimulus(1'b0, 32'd100, 32'd7);
    checkOutput("u100_7", 32'd14, 32'd2, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
    checkOutput("s_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b1, 32'd100, 32'hFFFF_FFF9);
    checkOutput("s_100_m7", 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    checkOutput("s_m100_m7", 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b0, 32'h0000_1234, 32'd0);
    checkOutput("div_zero", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd0);
    checkOutput("s_div_zero", 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("s_overflow", 32'h8000_0000, 32'd0, 1'b0, 1'b1, 0, 0);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("u_min_ones", 32'd0, 32'h8000_0000, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd1);
    checkOutput("s_min_1", 32'h8000_0000, 32'd0, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd2);
    checkOutput("s_min_2", 32'hC000_0000, 32'd0, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
    checkOutput("u_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, NORMAL_LAT, 0);
    applyStimulus(1'b0, 32'd5, 32'd9);
    checkOutput("u_small", 32'd0, 32'd5, 1'b0, 1'b0, NORMAL_LAT, 0);

    // Consumer stall: result must hold and new operands must be refused.
    applyStimulus(1'b0, 32'd1000, 32'd3);
    checkOutput("stall", 32'd333, 32'd1, 1'b0, 1'b0, NORMAL_LAT, 10);

    // Reset in the middle of a calculation discards it and clears the outputs.
    applyStimulus(1'b0, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(bus.out_valid), 64'(0));
    check("midreset_quotient", 64'(bus.quotient), 64'(0));
    check("midreset_remainder", 64'(bus.remainder), 64'(0));
    check("midreset_flags", 64'({bus.div_by_zero, bus.overflow}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midreset_in_ready", 64'(bus.in_ready), 64'(1));
    applyStimulus(1'b0, 32'h0000_00FF, 32'h0000_0001);
    checkOutput("after_reset", 32'h0000_00FF, 32'd0, 1'b0, 1'b0, NORMAL_LAT, 0);

    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      m = model(s, a, b);
      applyStimulus(s, a, b);
      checkOutput("random", m.q, m.r, m.dbz, m.ovf, (m.dbz || m.ovf) ? 0 : NORMAL_LAT, 0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
